// File: rtl/gray_updn_cnt.sv
// Up/down counter with registered binary and Gray outputs, optional saturation,
// and a Gray-coded load path enabled by defining GRAY_UPDN_CNT_LOAD_EN.
module gray_updn_cnt #(
  parameter int unsigned N       = 4,
  parameter int unsigned RST_VAL = 0,
  parameter bit          SAT     = 1'b0
) (
  input  logic         clk,
  input  logic         rstp,
  input  logic         en,
  input  logic         dir,
  input  logic         ld,
  input  logic [N-1:0] ld_gray,
  output logic [N-1:0] out,
  output logic [N-1:0] bin,
  output logic         at_max,
  output logic         at_min,
  output logic         wrap
);

  localparam logic [N-1:0] RST_BIN = N'(RST_VAL);
  localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};

  function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

`ifdef GRAY_UPDN_CNT_LOAD_EN
  function automatic logic [N-1:0] to_bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int unsigned i = 1; i < N; i++) begin
      b[N-1-i] = b[N-i] ^ g[N-1-i];
    end
    return b;
  endfunction
`else
  logic unused_load;
  assign unused_load = ^{ld, ld_gray};
`endif

  logic [N-1:0] nxt;
  logic         nxt_wrap;

  always_comb begin
    nxt      = bin;
    nxt_wrap = 1'b0;
    if (en) begin
      if (dir) begin
        if (bin == '1) begin
          if (!SAT) begin
            nxt      = '0;
            nxt_wrap = 1'b1;
          end
        end else begin
          nxt = bin + ONE;
        end
      end else begin
        if (bin == '0) begin
          if (!SAT) begin
            nxt      = '1;
            nxt_wrap = 1'b1;
          end
        end else begin
          nxt = bin - ONE;
        end
      end
    end
`ifdef GRAY_UPDN_CNT_LOAD_EN
    // Load overrides counting; the loaded Gray word is registered verbatim.
    if (ld) begin
      nxt      = to_bin(ld_gray);
      nxt_wrap = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rstp) begin
      bin    <= RST_BIN;
      out    <= to_gray(RST_BIN);
      at_max <= (RST_BIN == '1);
      at_min <= (RST_BIN == '0);
      wrap   <= 1'b0;
    end else begin
      bin    <= nxt;
      out    <= to_gray(nxt);
      at_max <= (nxt == '1);
      at_min <= (nxt == '0);
      wrap   <= nxt_wrap;
    end
  end

endmodule
